// File: rtl/cache_ctrl_2way.sv
// cache_ctrl_2way: 2-way set-associative write-back/write-allocate data cache
// with LRU replacement, invalid-way-first victim choice and hit/miss counters.
module cache_ctrl_2way #(
  parameter int LINE_WORDS = 4,
  parameter int SETS = 64,
  localparam int WB = $clog2(LINE_WORDS),
  localparam int IB = $clog2(SETS),
  localparam int TAG_W = 32 - 2 - WB - IB
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cs,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
);
  typedef enum logic [1:0] {S_IDLE, S_WB, S_FILL, S_DONE} state_t;
  state_t r_state;
  logic [31:0] r_data [2][SETS*LINE_WORDS];
  logic [TAG_W-1:0] r_tag [2][SETS];
  logic [SETS-1:0][1:0] r_valid, r_dirty;
  logic [SETS-1:0] r_lru;
  logic [TAG_W-1:0] r_rtag, r_vtag;
  logic [IB-1:0] r_idx;
  logic [WB-1:0] r_cnt;
  logic r_vway;
  logic [WB-1:0] w_word, w_cnt1;
  logic [IB-1:0] w_idx;
  logic [TAG_W-1:0] w_tag;
  logic w_h0, w_h1, w_hit, w_vway, w_vdirty, w_unused;
  assign w_word = addr[WB+1:2];
  assign w_idx = addr[WB+IB+1:WB+2];
  assign w_tag = addr[31:WB+IB+2];
  assign w_unused = ^addr[1:0];
  assign w_h0 = r_valid[w_idx][0] && r_tag[0][w_idx] == w_tag;
  assign w_h1 = r_valid[w_idx][1] && r_tag[1][w_idx] == w_tag;
  assign w_hit = cs && (w_h0 || w_h1);
  // r_lru names the way to evict next; an empty way always wins first
  assign w_vway = !r_valid[w_idx][0] ? 1'b0 : !r_valid[w_idx][1] ? 1'b1 : r_lru[w_idx];
  assign w_vdirty = r_valid[w_idx][w_vway] && r_dirty[w_idx][w_vway];
  assign w_cnt1 = r_cnt + 1'b1;
  assign stall = (r_state != S_IDLE) || (cs && !w_hit);
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_valid <= '0;
      r_dirty <= '0;
      r_lru <= '0;
      r_cnt <= '0;
      dout <= '0;
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      hit_cnt <= '0;
      miss_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE:
          if (w_hit) begin
            if (we) begin
              r_data[w_h1][{w_idx, w_word}] <= din;
              r_dirty[w_idx][w_h1] <= 1'b1;
            end else
              dout <= r_data[w_h1][{w_idx, w_word}];
            r_lru[w_idx] <= !w_h1;
            hit_cnt <= hit_cnt + 32'd1;
          end else if (cs) begin
            miss_cnt <= miss_cnt + 32'd1;
            r_cnt <= '0;
            r_rtag <= w_tag;
            r_idx <= w_idx;
            r_vway <= w_vway;
            r_vtag <= r_tag[w_vway][w_idx];
            mem_req <= 1'b1;
            mem_we <= w_vdirty;
            mem_addr <= {(w_vdirty ? r_tag[w_vway][w_idx] : w_tag), w_idx, {WB{1'b0}}, 2'b00};
            mem_wdata <= r_data[w_vway][{w_idx, {WB{1'b0}}}];
            r_state <= w_vdirty ? S_WB : S_FILL;
          end
        S_WB:
          if (mem_ack) begin
            r_cnt <= w_cnt1;
            mem_addr <= {(&r_cnt ? r_rtag : r_vtag), r_idx, w_cnt1, 2'b00};
            mem_wdata <= r_data[r_vway][{r_idx, w_cnt1}];
            if (&r_cnt) begin
              mem_we <= 1'b0;
              r_state <= S_FILL;
            end
          end
        S_FILL:
          if (mem_ack) begin
            r_data[r_vway][{r_idx, r_cnt}] <= mem_rdata;
            r_cnt <= w_cnt1;
            mem_addr <= {r_rtag, r_idx, w_cnt1, 2'b00};
            if (&r_cnt) begin
              r_tag[r_vway][r_idx] <= r_rtag;
              r_valid[r_idx][r_vway] <= 1'b1;
              r_dirty[r_idx][r_vway] <= 1'b0;
              mem_req <= 1'b0;
              r_state <= S_DONE;
            end
          end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cache_ctrl_2way.sv
// tb_cache_ctrl_2way: directed and randomized checks of cache_ctrl_2way against
// a flat-memory plus per-set LRU-list reference model.
module tb_cache_ctrl_2way;
  logic clk = 0, rst = 1, cs = 0, we = 0, mem_ack = 0;
  logic [31:0] addr = 0, din = 0, mem_rdata = 0;
  logic [31:0] dout, mem_addr, mem_wdata, hit_cnt, miss_cnt;
  logic stall, mem_req, mem_we;
  logic cs8 = 0, we8 = 0;
  logic [31:0] addr8 = 0, din8 = 0;
  logic [31:0] dout8, mem_addr8, mem_wdata8, mem_rdata8, hit8, miss8;
  logic stall8, mem_req8, mem_we8, mem_ack8;

  cache_ctrl_2way dut (.clk(clk), .rst(rst), .cs(cs), .we(we), .addr(addr), .din(din),
    .dout(dout), .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .hit_cnt(hit_cnt),
    .miss_cnt(miss_cnt));

  cache_ctrl_2way #(.LINE_WORDS(8), .SETS(16)) dut8 (.clk(clk), .rst(rst), .cs(cs8), .we(we8),
    .addr(addr8), .din(din8), .dout(dout8), .stall(stall8), .mem_req(mem_req8), .mem_we(mem_we8),
    .mem_addr(mem_addr8), .mem_wdata(mem_wdata8), .mem_rdata(mem_rdata8), .mem_ack(mem_ack8),
    .hit_cnt(hit8), .miss_cnt(miss8));

  always #5 clk = ~clk;

  int nvec = 0, nerr = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  logic [31:0] mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  function automatic logic [31:0] init_val(input logic [31:0] a);
    return a ^ 32'h3C3C_0000;
  endfunction
  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : init_val(a);
  endfunction
  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  // memory responder with 0..maxw random wait cycles and a hold checker
  int maxw = 0, wc = 0;
  logic p_pend = 0, p_we = 0;
  logic [31:0] p_addr = 0, p_wdata = 0;
  always @(negedge clk) begin
    if (p_pend && mem_req) begin
      chk("mem_addr_hold", mem_addr, p_addr);
      chk("mem_we_hold", mem_we, p_we);
      if (p_we) chk("mem_wdata_hold", mem_wdata, p_wdata);
    end
    if (rst || !mem_req) begin
      mem_ack = 0;
      wc = $urandom_range(maxw, 0);
    end else if (wc == 0) begin
      mem_ack = 1;
      mem_rdata = mem_rd(mem_addr);
      wc = $urandom_range(maxw, 0);
    end else begin
      mem_ack = 0;
      wc--;
    end
    p_pend = !rst && mem_req && !mem_ack;
    p_addr = mem_addr;
    p_we = mem_we;
    p_wdata = mem_wdata;
  end

  typedef struct packed {logic we; logic [31:0] a; logic [31:0] d;} tr_t;
  tr_t trl[$];
  always @(posedge clk)
    if (!rst && mem_req && mem_ack) begin
      trl.push_back('{mem_we, mem_addr, mem_wdata});
      if (mem_we) mem[mem_addr] = mem_wdata;
    end

  assign mem_ack8 = mem_req8;
  assign mem_rdata8 = mem_addr8 ^ 32'h8888_0000;
  logic [31:0] a8q[$];
  always @(posedge clk) if (!rst && mem_req8 && mem_ack8) a8q.push_back(mem_addr8);

  // reference: per set an MRU/LRU pair of tags, dirty set of line numbers
  logic [31:0] m_a [64], m_b [64];
  int m_n [64];
  bit dirty [logic [31:0]];
  logic [31:0] e_hit = 0, e_miss = 0;

  task automatic model_reset();
    foreach (m_n[i]) m_n[i] = 0;
    dirty.delete();
    e_hit = 0;
    e_miss = 0;
    ref_mem.delete();
    foreach (mem[k]) ref_mem[k] = mem[k];
  endtask

  task automatic access(input bit w, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] wa, t, ln, vl;
    int s, n, en;
    bit hit, wbk;
    wa = a & ~32'h3;
    s = int'((wa >> 4) % 64);
    t = wa >> 10;
    ln = wa >> 4;
    hit = (m_n[s] > 0 && m_a[s] == t) || (m_n[s] > 1 && m_b[s] == t);
    wbk = 0;
    if (!hit) begin
      e_miss++;
      if (m_n[s] == 2) begin
        vl = m_b[s] * 64 + s;
        wbk = dirty.exists(vl) != 0;
        dirty.delete(vl);
      end
      m_b[s] = m_a[s];
      m_a[s] = t;
      m_n[s] = (m_n[s] == 2) ? 2 : m_n[s] + 1;
    end else if (m_a[s] != t) begin
      m_b[s] = m_a[s];
      m_a[s] = t;
    end
    e_hit++;
    if (w) begin
      ref_mem[wa] = d;
      dirty[ln] = 1;
    end
    en = hit ? 0 : wbk ? 10 : 6;
    @(negedge clk);
    cs = 1; we = w; addr = a; din = d; n = 0;
    #1;
    while (stall && n < 400) begin
      @(negedge clk);
      #1;
      n++;
    end
    @(negedge clk);
    cs = 0; we = 0;
    if (maxw == 0) chk("stall_cycles", n, en);
    else chk("stall_min", (n >= en && n < 400) ? 1 : 0, 1);
    if (!w) chk("rdata", dout, ref_rd(wa));
    chk("hit_cnt", hit_cnt, e_hit);
    chk("miss_cnt", miss_cnt, e_miss);
  endtask

  task automatic acc8(input logic [31:0] a, input int en);
    int n;
    @(negedge clk);
    cs8 = 1; addr8 = a; n = 0;
    #1;
    while (stall8 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    @(negedge clk);
    cs8 = 0;
    chk("l8_stall", n, en);
    chk("l8_rdata", dout8, a ^ 32'h8888_0000);
  endtask

  logic [31:0] wbd [4] = '{32'hA0, 32'h55, 32'hA2, 32'hA3};
  logic [31:0] ra;
  int k, g;

  initial begin
    mem[32'h100] = 32'hA0; mem[32'h104] = 32'hA1; mem[32'h108] = 32'hA2; mem[32'h10C] = 32'hA3;
    repeat (2) @(negedge clk);
    rst = 0;
    model_reset();
    chk("rst_stall", stall, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_dout", dout, 0);
    chk("rst_hit", hit_cnt, 0);
    chk("rst_miss", miss_cnt, 0);
    chk("rst_stall8", stall8, 0);

    trl.delete();
    access(0, 32'h100, 0);
    chk("cold_words", trl.size(), 4);
    for (int i = 0; i < 4 && i < trl.size(); i++) begin
      chk("cold_addr", trl[i].a, 32'h100 + 4 * i);
      chk("cold_we", trl[i].we, 0);
    end

    trl.delete();
    access(1, 32'h104, 32'h55);
    access(0, 32'h104, 0);
    chk("whit_no_mem", trl.size(), 0);

    trl.delete();
    access(0, 32'h500, 0);
    chk("lru1_words", trl.size(), 4);
    for (int i = 0; i < trl.size(); i++) chk("lru1_we", trl[i].we, 0);
    access(0, 32'h100, 0);
    trl.delete();
    access(0, 32'h900, 0);
    chk("lru2_words", trl.size(), 4);
    for (int i = 0; i < trl.size(); i++) chk("lru2_we", trl[i].we, 0);
    trl.delete();
    access(0, 32'h500, 0);
    chk("lru3_words", trl.size(), 8);
    for (int i = 0; i < 4 && i + 4 < trl.size(); i++) begin
      chk("wb_we", trl[i].we, 1);
      chk("wb_addr", trl[i].a, 32'h100 + 4 * i);
      chk("wb_data", trl[i].d, wbd[i]);
      chk("refill_we", trl[i+4].we, 0);
      chk("refill_addr", trl[i+4].a, 32'h500 + 4 * i);
    end

    maxw = 3;
    repeat (250) begin
      ra = ($urandom_range(4, 0) << 10) | ($urandom_range(2, 0) << 4) | ($urandom_range(3, 0) << 2);
      access($urandom_range(1, 0) == 1, ra, $urandom);
    end

    maxw = 0;
    trl.delete();
    @(negedge clk);
    cs = 1; we = 0; addr = 32'h0007_F000;
    k = 0; g = 0;
    while (k < 2 && g < 200) begin
      @(negedge clk);
      g++;
      k = 0;
      foreach (trl[i]) if (!trl[i].we) k++;
    end
    chk("fill_acks_seen", k, 2);
    rst = 1; cs = 0;
    @(posedge clk);
    #1;
    chk("midrst_mem_req", mem_req, 0);
    chk("midrst_stall", stall, 0);
    @(negedge clk);
    rst = 0;
    model_reset();
    access(0, 32'h100, 0);
    chk("midrst_miss_cnt", miss_cnt, 1);

    a8q.delete();
    acc8(32'h000, 10);
    chk("l8_fill_words", a8q.size(), 8);
    if (a8q.size() == 8) chk("l8_last_addr", a8q[7], 32'h1C);
    acc8(32'h200, 10);
    chk("l8_fill2_words", a8q.size(), 16);
    if (a8q.size() == 16) chk("l8_fill2_addr", a8q[8], 32'h200);
    acc8(32'h01C, 0);
    acc8(32'h21C, 0);
    chk("l8_hit_cnt", hit8, 4);
    chk("l8_miss_cnt", miss8, 2);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/cache_ctrl_2way.md
Name: cache_ctrl_2way

Overview:
- Parametrised 2-way set-associative write-back, write-allocate data cache with its own tag/valid/dirty/LRU/data storage.
- Sits between the CPU data port and a word-wide memory with a req/ack handshake.
- Generalises line size and set count over the current direct-mapped unit; adds LRU replacement, invalid-way-first victim choice and hit/miss counters.

Parameters:
- LINE_WORDS, 4, 32-bit words per line; power of 2, at least 2; WB = clog2(LINE_WORDS).
- SETS, 64, number of sets; power of 2, at least 2; IB = clog2(SETS).
- TAG_W, 32-2-WB-IB, tag width; derived, not overridden.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- cs  in  1  CPU access request
- we  in  1  1 = write, 0 = read
- addr  in  32  byte address; bits [1:0] ignored
- din  in  32  CPU write data
- dout  out  32  registered read data
- stall  out  1  CPU must hold cs/we/addr/din unchanged while high
- mem_req  out  1  memory word request
- mem_we  out  1  memory write enable
- mem_addr  out  32  word-aligned memory address
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data, valid with mem_ack
- mem_ack  in  1  one word transferred at this posedge
- hit_cnt  out  32  count of completed hits, wraps
- miss_cnt  out  32  count of misses, wraps

Behaviour:
- Address split: word = addr[WB+1:2], index = addr[WB+IB+1:WB+2], tag = addr[31:WB+IB+2].
- Reset: all valid, dirty and LRU bits cleared; dout=0; mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0; counters=0; state IDLE. Data array is not cleared.
- hit = cs and the valid tag of either way at index matches. Both ways matching is impossible by construction.
- stall (combinational) = (state != IDLE) or (cs and not hit).
- IDLE, cs and hit, at posedge:
  - Read: dout <= word, so dout is valid one cycle after the hit cycle.
  - Write: word <= din and dirty <= 1.
  - Both: lru[index] <= other way; hit_cnt++.
- IDLE, cs and miss:
  - Victim = first invalid way (way0 before way1); if both valid, way lru[index].
  - miss_cnt++ once; word counter <= 0.
  - Next state WB if victim is valid and dirty, else FILL.
- WB state:
  - Outputs: mem_req=1, mem_we=1, mem_addr={victim_tag, index, cnt, 2'b00}, mem_wdata = victim word cnt.
  - On mem_ack: cnt++. On ack with cnt = LINE_WORDS-1: cnt <= 0, go to FILL.
- FILL state:
  - Outputs: mem_req=1, mem_we=0, mem_addr={req_tag, index, cnt, 2'b00}.
  - On mem_ack: victim word cnt <= mem_rdata, cnt++.
  - On last ack: tag <= req_tag, valid <= 1, dirty <= 0, go to DONE.
- DONE state: one cycle, mem_req=0, then IDLE. The held request now hits and completes as above, with LRU and hit_cnt updated.
- Memory handshake:
  - mem_addr, mem_we and mem_wdata are stable while mem_req and not mem_ack.
  - mem_req may stay high across consecutive words.
  - Zero wait states means one word per cycle.
- Miss latency with zero waits: clean miss = 1 + LINE_WORDS + 1 cycles of stall; dirty miss adds LINE_WORDS.
- Miss request captured: tag and index are latched at the miss cycle. If cs drops mid-miss, the transfer still completes and the line is installed; no CPU write occurs.
- Reset mid-operation: at the reset edge the transfer is abandoned and all outputs return to reset values. Dirty data in flight is lost.
- Counters wrap at 2^32.
- Stalled cycles are not counted as hits.

Test Plan:
- Cold read miss: reset, read 0x100 with mem returning 0xA0..0xA3 at zero wait.
  -> stall for 6 cycles; mem reads at 0x100, 0x104, 0x108, 0x10C; dout=0xA0 on the cycle after stall falls; miss_cnt=1, hit_cnt=1.
- Write hit: write 0x104 din=0x55, then read 0x104.
  -> no stall, no mem_req, dout=0x55.
- LRU replacement: with the 0x100 line dirty, read 0x500 (same index 0x10), access 0x100, read 0x900, then read 0x500.
  -> 0x500 fills way1 with no writeback.
  -> 0x900 evicts clean 0x500 with no writeback.
  -> final 0x500 evicts dirty 0x100: 4 writes at 0x100..0x10C with data 0xA0, 0x55, 0xA2, 0xA3, then 4 reads at 0x500..0x50C.
- Wait states: random 0-3 cycles before each mem_ack.
  -> identical data results; mem_addr and mem_wdata never change while mem_req=1 and mem_ack=0.
- Reset mid-fill: assert rst after the second fill ack.
  -> next cycle mem_req=0 and stall=0; a read of 0x100 misses again with miss_cnt=1.
- Alternate parameters: LINE_WORDS=8, SETS=16.
  -> fill is 8 words with index = addr[8:5]; 0x000 and 0x200 coexist in both ways.
